// File: rtl/fp16_pkg.sv
// Shared widths, constants, FSM states and the binary16 field layout for the
// FP16 adder back end.
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int MAN_W   = 11;
  localparam int GRS_W   = 3;
  localparam int M_W     = MAN_W + GRS_W;
  localparam int EXP_MAX = 31;
  localparam int BIAS    = 15;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    NORM,
    ROUND,
    DONE
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-2:0] frac;
  } fp16_t;

endpackage

// File: rtl/fp16_rne_round.sv
// Combinational round-to-nearest-even, carry renormalize and binary16 pack.
// Build option: FTZ_EN flushes subnormal results to signed zero.
module fp16_rne_round
  import fp16_pkg::*;
(
  input  logic [M_W-1:0] m_i,
  input  logic [EXP_W:0] e_i,
  input  logic           s_i,
  input  logic           sub_i,
  output fp16_t          res_o,
  output logic           ovf_o,
  output logic           unf_o,
  output logic           inx_o,
  output logic           zero_o
);

  logic             up;
  logic             zsign;
  logic [MAN_W:0]   r;
  logic [MAN_W-1:0] rn;
  logic [EXP_W:0]   e_r;

  always_comb begin
    up    = m_i[2] & (m_i[3] | m_i[1] | m_i[0]);
    r     = {1'b0, m_i[M_W-1:GRS_W]} + (MAN_W+1)'(up);
    rn    = r[MAN_W] ? r[MAN_W:1] : r[MAN_W-1:0];
    e_r   = r[MAN_W] ? e_i + (EXP_W+1)'(1) : e_i;
    zsign = sub_i ? 1'b0 : s_i;

    res_o  = '0;
    ovf_o  = 1'b0;
    unf_o  = 1'b0;
    inx_o  = |m_i[2:0];
    zero_o = 1'b0;

    if (e_r >= (EXP_W+1)'(EXP_MAX)) begin
      res_o.sign = s_i;
      res_o.exp  = '1;
      ovf_o      = 1'b1;
      inx_o      = 1'b1;
    end
`ifdef FTZ_EN
    else if (!rn[MAN_W-1] && (rn != '0)) begin
      res_o.sign = zsign;
      unf_o      = 1'b1;
      inx_o      = 1'b1;
      zero_o     = 1'b1;
    end
`endif
    else begin
      // a subnormal carrying into the hidden bit picks up exp field 1 from e_r
      res_o.sign = (rn == '0) ? zsign : s_i;
      res_o.exp  = rn[MAN_W-1] ? e_r[EXP_W-1:0] : '0;
      res_o.frac = rn[MAN_W-2:0];
      unf_o      = ~rn[MAN_W-1] & inx_o;
      zero_o     = (rn == '0);
    end
  end

endmodule

// File: rtl/fp16_normalize_round.sv
// FP16 adder back end: iterative left-normalize, RNE round, pack, with
// valid/ready on both sides. Build option: FTZ_EN (flush-to-zero).
module fp16_normalize_round #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W+3:0]       in_sum,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic                   in_sign,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] out_result,
  output logic                   out_overflow,
  output logic                   out_underflow,
  output logic                   out_inexact,
  output logic                   out_zero
);
  import fp16_pkg::*;

  localparam int MW = MAN_W + GRS_W;

  state_e          state_q, state_d;
  logic [MW:0]     sum_q, sum_d;
  logic [MW-1:0]   m_q, m_d;
  logic [EXP_W:0]  e_q, e_d;
  logic            s_q, s_d, sub_q, sub_d;
  fp16_t           res_q, res_d, rnd_res;
  logic            ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d, zro_q, zro_d;
  logic            rnd_ovf, rnd_unf, rnd_inx, rnd_zro;
  logic            shift_ok;

  assign shift_ok = ~m_q[MW-1] && (m_q != '0) && (e_q > (EXP_W+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = PRE;
      PRE:     state_d = NORM;
      NORM:    if (!shift_ok) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    sum_d = sum_q;
    m_d   = m_q;
    e_d   = e_q;
    s_d   = s_q;
    sub_d = sub_q;
    res_d = res_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    inx_d = inx_q;
    zro_d = zro_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        sum_d = in_sum;
        e_d   = {1'b0, (in_exp == '0) ? EXP_W'(1) : in_exp};
        s_d   = in_sign;
        sub_d = in_sub;
      end
      PRE: begin
        // carry out: drop one bit into sticky and bump the exponent
        if (sum_q[MW]) begin
          m_d = {sum_q[MW:2], sum_q[1] | sum_q[0]};
          e_d = e_q + (EXP_W+1)'(1);
        end else begin
          m_d = sum_q[MW-1:0];
        end
      end
      NORM: if (shift_ok) begin
        m_d = {m_q[MW-2:0], 1'b0};
        e_d = e_q - (EXP_W+1)'(1);
      end
      ROUND: begin
        res_d = rnd_res;
        ovf_d = rnd_ovf;
        unf_d = rnd_unf;
        inx_d = rnd_inx;
        zro_d = rnd_zro;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      m_q   <= '0;
      e_q   <= '0;
      s_q   <= 1'b0;
      sub_q <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inx_q <= 1'b0;
      zro_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      m_q   <= m_d;
      e_q   <= e_d;
      s_q   <= s_d;
      sub_q <= sub_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      inx_q <= inx_d;
      zro_q <= zro_d;
    end
  end

  fp16_rne_round u_round (
    .m_i    (m_q),
    .e_i    (e_q),
    .s_i    (s_q),
    .sub_i  (sub_q),
    .res_o  (rnd_res),
    .ovf_o  (rnd_ovf),
    .unf_o  (rnd_unf),
    .inx_o  (rnd_inx),
    .zero_o (rnd_zro)
  );

  assign out_result    = res_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_inexact   = inx_q;
  assign out_zero      = zro_q;

endmodule
